// File: rtl/teclado_barrido_if.sv
// Keypad pin and key-event bundle for teclado_barrido.
// Bit 0 of fila/columna is Fila1/Columna1, and bit 3 is Fila4/Columna4.
interface teclado_if;
    logic [3:0] fila;
    logic [3:0] columna;
    logic [3:0] tecla;
    logic       teclaValida;
    logic       botonApretado;

    modport master (
        input  fila,
        output columna,
        output tecla,
        output teclaValida,
        output botonApretado
    );

    modport slave (
        output fila,
        input  columna,
        input  tecla,
        input  teclaValida,
        input  botonApretado
    );
endinterface

// File: rtl/teclado_barrido.sv
// 4x4 keypad scanner: one-hot column drive, synchronized and debounced rows, 4-bit key code plus strobe.
// Define TECLADO_REPEAT_EN to re-strobe a held key after REPEAT_DELAY, then every REPEAT_RATE clocks.
module teclado_barrido #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 20000,
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_RATE  = 100000
) (
    input  logic       Clk,
    input  logic       Reset,
    teclado_if.master  kbd
);
    localparam int CNT_TOP = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
    localparam int CNT_W   = (CNT_TOP > 2) ? $clog2(CNT_TOP) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       fila_meta_q, filas_s_q;
    logic [3:0]       col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       tecla_q, tecla_d;
    logic             valida_q, valida_d;
    logic             boton_q, boton_d;
    logic             strobe_first;
    logic             repeat_fire;
    logic             row_hit;
    logic [1:0]       lowest_row;
    logic [1:0]       cur_col;
    logic [3:0]       col_rot;

    assign row_hit = filas_s_q[row_idx_q];
    assign col_rot = {col_q[2:0], col_q[3]};

    always_comb begin
        lowest_row = 2'd0;
        if (filas_s_q[0])      lowest_row = 2'd0;
        else if (filas_s_q[1]) lowest_row = 2'd1;
        else if (filas_s_q[2]) lowest_row = 2'd2;
        else if (filas_s_q[3]) lowest_row = 2'd3;
    end

    always_comb begin
        cur_col = 2'd0;
        if (col_q[1])      cur_col = 2'd1;
        else if (col_q[2]) cur_col = 2'd2;
        else if (col_q[3]) cur_col = 2'd3;
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        cnt_d        = cnt_q;
        row_idx_d    = row_idx_q;
        col_idx_d    = col_idx_q;
        tecla_d      = tecla_q;
        boton_d      = boton_q;
        strobe_first = 1'b0;
        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (filas_s_q != 4'd0) begin
                        row_idx_d = lowest_row;
                        col_idx_d = cur_col;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_d = col_rot;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!row_hit) begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d        = '0;
                    tecla_d      = {row_idx_q, col_idx_q};
                    strobe_first = 1'b1;
                    boton_d      = 1'b1;
                    state_d      = PRESSED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                // Only the latched row matters; extra rows pressed meanwhile are ignored.
                if (!row_hit) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (row_hit) begin
                    state_d = PRESSED;
                end else if (filas_s_q != 4'd0) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    boton_d = 1'b0;
                    col_d   = col_rot;
                    state_d = SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

`ifdef TECLADO_REPEAT_EN
    localparam int RCNT_TOP = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCNT_W   = (RCNT_TOP > 2) ? $clog2(RCNT_TOP) : 1;
    localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              rep_seen_q, rep_seen_d;

    // rcnt is held through RELEASE so a bounce back to PRESSED resumes the same schedule.
    always_comb begin
        rcnt_d      = rcnt_q;
        rep_seen_d  = rep_seen_q;
        repeat_fire = 1'b0;
        if (strobe_first) begin
            rcnt_d     = '0;
            rep_seen_d = 1'b0;
        end else if (state_q == PRESSED && row_hit) begin
            if ((!rep_seen_q && rcnt_q == DELAY_LAST) || (rep_seen_q && rcnt_q == RATE_LAST)) begin
                repeat_fire = 1'b1;
                rcnt_d      = '0;
                rep_seen_d  = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end else if (state_q == RELEASE && state_d == SCAN) begin
            rcnt_d     = '0;
            rep_seen_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rcnt_q     <= '0;
            rep_seen_q <= 1'b0;
        end else begin
            rcnt_q     <= rcnt_d;
            rep_seen_q <= rep_seen_d;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    assign valida_d = strobe_first | repeat_fire;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fila_meta_q <= 4'd0;
            filas_s_q   <= 4'd0;
            state_q     <= SCAN;
            col_q       <= 4'b0001;
            cnt_q       <= '0;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            tecla_q     <= 4'd0;
            valida_q    <= 1'b0;
            boton_q     <= 1'b0;
        end else begin
            fila_meta_q <= kbd.fila;
            filas_s_q   <= fila_meta_q;
            state_q     <= state_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            tecla_q     <= tecla_d;
            valida_q    <= valida_d;
            boton_q     <= boton_d;
        end
    end

    assign kbd.columna       = col_q;
    assign kbd.tecla         = tecla_q;
    assign kbd.teclaValida   = valida_q;
    assign kbd.botonApretado = boton_q;
endmodule
